// File: rtl/sa_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sa_pkg
//  Description : Shared types, default sizes and requantisation helpers for
//                the systolic-array output drain.
//  Revision    : 1.0 - initial release
// ============================================================================
package sa_pkg;

    // Default geometry of the array the drain sits behind.
    localparam int SA_WIDTH          = 16;
    localparam int SA_HIDDEN_SIZE    = 4;
    localparam int SA_CONTEXT_LENGTH = 4;
    localparam int SA_OUT_WIDTH      = 16;
    localparam int PSUM_W            = 2 * SA_WIDTH;

    // Drain controller states.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_t;

    // Wide signed working type: one bit of headroom over a 64-bit psum, so
    // the rounding addend can never overflow for any supported WIDTH (<= 32).
    typedef logic signed [64:0] wide_t;

    // Rounding arithmetic right shift, ties go toward +inf.
    function automatic wide_t rq_round(input wide_t x, input int unsigned s);
        if (s == 0) begin
            return x;
        end
        return (x + (wide_t'(1) << (s - 1))) >>> s;
    endfunction

    // True when r exceeds the largest value representable in w signed bits.
    function automatic bit rq_over(input wide_t r, input int unsigned w);
        return r > ((wide_t'(1) <<< (w - 1)) - wide_t'(1));
    endfunction

    // True when r is below the smallest value representable in w signed bits.
    function automatic bit rq_under(input wide_t r, input int unsigned w);
        return r < -(wide_t'(1) <<< (w - 1));
    endfunction

endpackage : sa_pkg
`default_nettype wire

// File: rtl/sa_output_drain_if.sv
`default_nettype none
// ============================================================================
//  Module      : sa_output_drain_if
//  Description : Matrix capture handshake plus element stream handshake of
//                the output drain. master = upstream/downstream environment,
//                slave = drain block.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sa_output_drain_if
    import sa_pkg::*;
#(
    parameter int WIDTH          = SA_WIDTH,
    parameter int HIDDEN_SIZE    = SA_HIDDEN_SIZE,
    parameter int CONTEXT_LENGTH = SA_CONTEXT_LENGTH,
    parameter int OUT_WIDTH      = SA_OUT_WIDTH
);
    localparam int c_psum_w  = 2 * WIDTH;
    localparam int c_shift_w = $clog2(c_psum_w);
    localparam int c_row_w   = (HIDDEN_SIZE > 1) ? $clog2(HIDDEN_SIZE) : 1;
    localparam int c_col_w   = (CONTEXT_LENGTH > 1) ? $clog2(CONTEXT_LENGTH) : 1;

    logic                                                    y_valid;
    logic                                                    y_ready;
    logic [HIDDEN_SIZE-1:0][CONTEXT_LENGTH-1:0][c_psum_w-1:0] y_in;
    logic [c_shift_w-1:0]                                    shift_amt;

    logic                                                    out_valid;
    logic                                                    out_ready;
    logic signed [OUT_WIDTH-1:0]                             out_data;
    logic [c_row_w-1:0]                                      out_row;
    logic [c_col_w-1:0]                                      out_col;
    logic                                                    out_last;
    logic                                                    sat_flag;

    modport master (
        output y_valid, y_in, shift_amt, out_ready,
        input  y_ready, out_valid, out_data, out_row, out_col, out_last, sat_flag
    );

    modport slave (
        input  y_valid, y_in, shift_amt, out_ready,
        output y_ready, out_valid, out_data, out_row, out_col, out_last, sat_flag
    );

endinterface : sa_output_drain_if
`default_nettype wire

// File: rtl/sa_requant_sat.sv
`default_nettype none
// ============================================================================
//  Module      : sa_requant_sat
//  Description : Combinational requantiser: rounding arithmetic right shift
//                of a psum followed by saturation to OUT_WIDTH bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module sa_requant_sat
    import sa_pkg::*;
#(
    parameter int PSUM_W_P  = PSUM_W,
    parameter int SHIFT_W   = $clog2(PSUM_W),
    parameter int OUT_WIDTH = SA_OUT_WIDTH
) (
    input  logic signed [PSUM_W_P-1:0]  x,
    input  logic        [SHIFT_W-1:0]   s,
    output logic signed [OUT_WIDTH-1:0] r,
    output logic                        sat
);
    localparam logic signed [OUT_WIDTH-1:0] c_out_max = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [OUT_WIDTH-1:0] c_out_min = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    wide_t w_rounded;

    // Round in the wide domain, then clamp and flag any clamping.
    always_comb begin
        w_rounded = rq_round(wide_t'(x), 32'(s));
        r         = w_rounded[OUT_WIDTH-1:0];
        sat       = 1'b0;
        if (rq_over(w_rounded, OUT_WIDTH)) begin
            r   = c_out_max;
            sat = 1'b1;
        end else if (rq_under(w_rounded, OUT_WIDTH)) begin
            r   = c_out_min;
            sat = 1'b1;
        end
    end

endmodule : sa_requant_sat
`default_nettype wire

// File: rtl/sa_output_drain.sv
`default_nettype none
// ============================================================================
//  Module      : sa_output_drain
//  Description : Captures a full psum matrix in one edge, requantises each
//                element and streams them token-major (column outer, row
//                inner) over a valid/ready interface with no bubbles.
//  Revision    : 1.0 - initial release
// ============================================================================
module sa_output_drain
    import sa_pkg::*;
#(
    parameter int WIDTH          = SA_WIDTH,
    parameter int HIDDEN_SIZE    = SA_HIDDEN_SIZE,
    parameter int CONTEXT_LENGTH = SA_CONTEXT_LENGTH,
    parameter int OUT_WIDTH      = SA_OUT_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    sa_output_drain_if.slave  bus
);
    localparam int c_psum_w  = 2 * WIDTH;
    localparam int c_shift_w = $clog2(c_psum_w);
    localparam int c_row_w   = (HIDDEN_SIZE > 1) ? $clog2(HIDDEN_SIZE) : 1;
    localparam int c_col_w   = (CONTEXT_LENGTH > 1) ? $clog2(CONTEXT_LENGTH) : 1;
    localparam logic [c_row_w-1:0]   c_row_max   = c_row_w'(HIDDEN_SIZE - 1);
    localparam logic [c_col_w-1:0]   c_col_max   = c_col_w'(CONTEXT_LENGTH - 1);
    localparam logic [c_shift_w-1:0] c_shift_max = c_shift_w'(c_psum_w - 1);

    drain_state_t r_state, w_state_nxt;

    logic [HIDDEN_SIZE-1:0][CONTEXT_LENGTH-1:0][c_psum_w-1:0] r_buf;
    logic [c_shift_w-1:0]        r_shift;
    logic [c_row_w-1:0]          r_ni;      // row of the next element to load
    logic [c_col_w-1:0]          r_nj;      // column of the next element to load
    logic                        r_more;    // elements remain to be loaded

    logic                        r_out_valid;
    logic signed [OUT_WIDTH-1:0] r_out_data;
    logic [c_row_w-1:0]          r_out_row;
    logic [c_col_w-1:0]          r_out_col;
    logic                        r_out_last;
    logic                        r_sat_flag;

    logic                        w_capture;
    logic                        w_hs;
    logic                        w_load;
    logic                        w_at_end;
    logic signed [c_psum_w-1:0]  w_sel;
    logic signed [OUT_WIDTH-1:0] w_rq;
    logic                        w_sat;

    assign w_capture = bus.y_valid && (r_state == IDLE);
    assign w_hs      = r_out_valid && bus.out_ready;
    // The output register refills whenever it is empty or being emptied.
    assign w_load    = (r_state == DRAIN) && r_more && (!r_out_valid || bus.out_ready);
    assign w_at_end  = (r_ni == c_row_max) && (r_nj == c_col_max);
    assign w_sel     = r_buf[r_ni][r_nj];

    sa_requant_sat #(
        .PSUM_W_P  (c_psum_w),
        .SHIFT_W   (c_shift_w),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_requant (
        .x   (w_sel),
        .s   (r_shift),
        .r   (w_rq),
        .sat (w_sat)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: capture starts a drain, the final handshake ends it.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.y_valid) w_state_nxt = DRAIN;
            DRAIN:   if (w_hs && r_out_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Matrix buffer and clamped shift; contents need no reset.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_buf   <= bus.y_in;
            r_shift <= (bus.shift_amt > c_shift_max) ? c_shift_max : bus.shift_amt;
        end
    end

    // Element walk and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ni        <= '0;
            r_nj        <= '0;
            r_more      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_row   <= '0;
            r_out_col   <= '0;
            r_out_last  <= 1'b0;
            r_sat_flag  <= 1'b0;
        end else if (w_capture) begin
            r_ni        <= '0;
            r_nj        <= '0;
            r_more      <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_sat_flag  <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_rq;
            r_out_row   <= r_ni;
            r_out_col   <= r_nj;
            r_out_last  <= w_at_end;
            if (w_sat) begin
                r_sat_flag <= 1'b1;
            end
            if (w_at_end) begin
                r_more <= 1'b0;
            end else if (r_ni == c_row_max) begin
                r_ni <= '0;
                r_nj <= r_nj + c_col_w'(1);
            end else begin
                r_ni <= r_ni + c_row_w'(1);
            end
        end else if (w_hs) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end
    end

    assign bus.y_ready   = (r_state == IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_row   = r_out_row;
    assign bus.out_col   = r_out_col;
    assign bus.out_last  = r_out_last;
    assign bus.sat_flag  = r_sat_flag;

endmodule : sa_output_drain
`default_nettype wire

// File: tb/tb_sa_output_drain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sa_output_drain
//  Description : Self-checking bench for sa_output_drain with an arithmetic
//                reference model of requantisation and stream order.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sa_output_drain;

    localparam int HS   = 4;
    localparam int CL   = 4;
    localparam int NEL  = HS * CL;
    localparam int MAXS = 400;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sa_output_drain_if bus ();

    sa_output_drain dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    longint mat [HS][CL];
    bit     pat6 [6];

    // Per-cycle snapshots and accepted beats of one stream.
    bit     s_valid [MAXS];
    bit     s_ready [MAXS];
    bit     s_last  [MAXS];
    bit     s_yrdy  [MAXS];
    longint s_data  [MAXS];
    int     s_row   [MAXS];
    int     s_col   [MAXS];
    int     n_snap;
    longint b_data [32];
    int     b_row  [32];
    int     b_col  [32];
    bit     b_last [32];
    int     n_beats;
    bit     timed_out;

    // Expected stream.
    longint e_data [NEL];
    int     e_row  [NEL];
    int     e_col  [NEL];
    bit     e_last [NEL];
    bit     e_sat;

    // Reference requantiser: floor((x + 2^(s-1)) / 2^s), then clamp.
    function automatic void model_rq(input longint x, input int s, output longint r, output bit sat);
        longint d, num, q;
        int     se;
        se = (s > 31) ? 31 : s;
        if (se == 0) begin
            q = x;
        end else begin
            d   = longint'(1) << se;
            num = x + d / 2;
            q   = num / d;
            if ((num % d) != 0 && num < 0) q = q - 1;
        end
        sat = 1'b0;
        if (q > 32767) begin
            r = 32767; sat = 1'b1;
        end else if (q < -32768) begin
            r = -32768; sat = 1'b1;
        end else begin
            r = q;
        end
    endfunction

    function automatic void build_expected(input int shift);
        int     k;
        longint r;
        bit     s;
        k = 0;
        e_sat = 1'b0;
        for (int j = 0; j < CL; j++) begin
            for (int i = 0; i < HS; i++) begin
                model_rq(mat[i][j], shift, r, s);
                e_data[k] = r;
                e_row[k]  = i;
                e_col[k]  = j;
                e_last[k] = (k == NEL - 1);
                e_sat     = e_sat | s;
                k++;
            end
        end
    endfunction

    function automatic longint rand_psum();
        longint v;
        v = longint'($signed($urandom()));
        return v >>> $urandom_range(0, 31);
    endfunction

    task automatic drive_matrix();
        longint v;
        for (int i = 0; i < HS; i++) begin
            for (int j = 0; j < CL; j++) begin
                v = mat[i][j];
                bus.y_in[i][j] = v[31:0];
            end
        end
    endtask

    task automatic random_matrix();
        for (int i = 0; i < HS; i++)
            for (int j = 0; j < CL; j++)
                mat[i][j] = rand_psum();
    endtask

    // Presents y_valid until a capture edge passes; returns at the next negedge.
    task automatic capture(input int shift, input bit hold, output int waits, output bit ok);
        bit hs;
        bus.shift_amt = 5'(shift);
        bus.y_valid   = 1'b1;
        ok    = 1'b0;
        waits = 0;
        for (int k = 0; k < 60; k++) begin
            hs = bus.y_ready;
            @(negedge clk);
            if (hs) begin
                ok = 1'b1;
                break;
            end
            waits++;
        end
        if (!hold) bus.y_valid = 1'b0;
    endtask

    // Records one stream until the last handshake; mode 0 ready=1, 1 fixed pattern, 2 random.
    task automatic collect(input int mode);
        bit rdy;
        n_snap    = 0;
        n_beats   = 0;
        timed_out = 1'b1;
        for (int c = 0; c < MAXS; c++) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = pat6[c % 6];
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            bus.out_ready = rdy;
            s_valid[c] = bus.out_valid;
            s_ready[c] = rdy;
            s_last[c]  = bus.out_last;
            s_yrdy[c]  = bus.y_ready;
            s_data[c]  = longint'(bus.out_data);
            s_row[c]   = int'(bus.out_row);
            s_col[c]   = int'(bus.out_col);
            n_snap     = c + 1;
            if (bus.out_valid && rdy && n_beats < 32) begin
                b_data[n_beats] = s_data[c];
                b_row[n_beats]  = s_row[c];
                b_col[n_beats]  = s_col[c];
                b_last[n_beats] = s_last[c];
                n_beats++;
            end
            @(negedge clk);
            if (s_valid[c] && rdy && s_last[c]) begin
                timed_out = 1'b0;
                break;
            end
        end
        bus.out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.y_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.shift_amt = '0;
        bus.y_in = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.y_ready, bus.out_valid, bus.out_last, bus.sat_flag} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_flags: got ready/valid/last/sat=%b%b%b%b want 1000", bus.y_ready, bus.out_valid, bus.out_last, bus.sat_flag);
        end
        checks++;
        if ({bus.out_data, bus.out_row, bus.out_col} !== 20'd0) begin
            errors++;
            $display("FAIL reset_data: got data=%0d row=%0d col=%0d want 0", bus.out_data, bus.out_row, bus.out_col);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.y_ready, bus.out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL reset_release: got y_ready=%b out_valid=%b want 1 0", bus.y_ready, bus.out_valid);
        end
    endtask

    task automatic test_order();
        int w; bit ok; int busy;
        for (int i = 0; i < HS; i++)
            for (int j = 0; j < CL; j++)
                mat[i][j] = 4 * i + j;
        drive_matrix();
        build_expected(0);
        capture(0, 1'b0, w, ok);
        collect(0);
        checks++;
        if (!ok || timed_out || n_beats != NEL) begin
            errors++;
            $display("FAIL order_count: ok=%b timeout=%b beats=%0d want 1 0 16", ok, timed_out, n_beats);
        end
        checks++;
        if (n_snap != NEL + 1 || s_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL order_latency: cycles=%0d first_valid=%b want 17 0", n_snap, s_valid[0]);
        end
        for (int k = 0; k < NEL && k < n_beats; k++) begin
            checks++;
            if ({b_data[k], b_row[k], b_col[k], b_last[k]} !== {e_data[k], e_row[k], e_col[k], e_last[k]}) begin
                errors++;
                $display("FAIL order_beat%0d: got d=%0d r=%0d c=%0d l=%b want d=%0d r=%0d c=%0d l=%b",
                         k, b_data[k], b_row[k], b_col[k], b_last[k], e_data[k], e_row[k], e_col[k], e_last[k]);
            end
        end
        busy = 0;
        for (int c = 0; c < n_snap; c++) busy += int'(s_yrdy[c]);
        checks++;
        if (busy != 0 || bus.y_ready !== 1'b1) begin
            errors++;
            $display("FAIL order_y_ready: high during drain %0d times, after=%b want 0 and 1", busy, bus.y_ready);
        end
    endtask

    task automatic test_rounding();
        int w; bit ok;
        int shifts [2];
        longint xa [2], xb [2], ra [2], rb [2];
        shifts[0] = 1; xa[0] = 5;  xb[0] = -5; ra[0] = 3; rb[0] = -2;
        shifts[1] = 2; xa[1] = 6;  xb[1] = -6; ra[1] = 2; rb[1] = -1;
        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < HS; i++)
                for (int j = 0; j < CL; j++)
                    mat[i][j] = 7 * i - 3 * j;
            mat[0][0] = xa[t];
            mat[1][0] = xb[t];
            drive_matrix();
            build_expected(shifts[t]);
            capture(shifts[t], 1'b0, w, ok);
            collect(2);
            checks++;
            if (timed_out || n_beats != NEL || b_data[0] != ra[t] || b_data[1] != rb[t]) begin
                errors++;
                $display("FAIL round_s%0d: beats=%0d got %0d,%0d want %0d,%0d", shifts[t], n_beats, b_data[0], b_data[1], ra[t], rb[t]);
            end
            for (int k = 2; k < NEL && k < n_beats; k++) begin
                checks++;
                if (b_data[k] != e_data[k]) begin
                    errors++;
                    $display("FAIL round_beat%0d: got %0d want %0d", k, b_data[k], e_data[k]);
                end
            end
            checks++;
            if (bus.sat_flag !== 1'b0) begin
                errors++;
                $display("FAIL round_sat: got sat_flag=%b want 0", bus.sat_flag);
            end
        end
    endtask

    task automatic test_saturation();
        int w; bit ok;
        for (int i = 0; i < HS; i++)
            for (int j = 0; j < CL; j++)
                mat[i][j] = i * 100 - j * 50;
        mat[0][0] = 100000;
        mat[1][0] = -100000;
        drive_matrix();
        capture(0, 1'b0, w, ok);
        collect(0);
        checks++;
        if (timed_out || b_data[0] != 32767 || b_data[1] != -32768) begin
            errors++;
            $display("FAIL sat_clamp: got %0d,%0d want 32767,-32768", b_data[0], b_data[1]);
        end
        checks++;
        if (bus.sat_flag !== 1'b1) begin
            errors++;
            $display("FAIL sat_flag_set: got %b want 1", bus.sat_flag);
        end
        mat[0][0] = 1;
        mat[1][0] = -1;
        drive_matrix();
        capture(0, 1'b0, w, ok);
        checks++;
        if (bus.sat_flag !== 1'b0) begin
            errors++;
            $display("FAIL sat_flag_clear: got %b want 0 after capture", bus.sat_flag);
        end
        collect(0);
    endtask

    task automatic test_backpressure();
        int w; bit ok;
        random_matrix();
        drive_matrix();
        build_expected(3);
        capture(3, 1'b0, w, ok);
        collect(1);
        checks++;
        if (timed_out || n_beats != NEL) begin
            errors++;
            $display("FAIL bp_count: timeout=%b beats=%0d want 0 16", timed_out, n_beats);
        end
        for (int k = 0; k < NEL && k < n_beats; k++) begin
            checks++;
            if ({b_data[k], b_row[k], b_col[k], b_last[k]} !== {e_data[k], e_row[k], e_col[k], e_last[k]}) begin
                errors++;
                $display("FAIL bp_beat%0d: got d=%0d r=%0d c=%0d want d=%0d r=%0d c=%0d", k, b_data[k], b_row[k], b_col[k], e_data[k], e_row[k], e_col[k]);
            end
        end
        for (int c = 0; c + 1 < n_snap; c++) begin
            if (s_valid[c] && !s_ready[c]) begin
                checks++;
                if ({s_valid[c+1], s_data[c+1], s_row[c+1], s_col[c+1], s_last[c+1]} !==
                    {s_valid[c], s_data[c], s_row[c], s_col[c], s_last[c]}) begin
                    errors++;
                    $display("FAIL bp_stall_cycle%0d: got d=%0d r=%0d c=%0d want d=%0d r=%0d c=%0d held",
                             c, s_data[c+1], s_row[c+1], s_col[c+1], s_data[c], s_row[c], s_col[c]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int w; bit ok; int hs;
        random_matrix();
        mat[0][0] = longint'(1) << 30;
        drive_matrix();
        capture(2, 1'b0, w, ok);
        bus.out_ready = 1'b1;
        hs = 0;
        for (int c = 0; c < 50 && hs < 5; c++) begin
            if (bus.out_valid) hs++;
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (hs != 5 || {bus.y_ready, bus.out_valid, bus.out_last, bus.sat_flag} !== 4'b1000) begin
            errors++;
            $display("FAIL midrst_flags: beats=%0d ready/valid/last/sat=%b%b%b%b want 5 1000", hs, bus.y_ready, bus.out_valid, bus.out_last, bus.sat_flag);
        end
        checks++;
        if ({bus.out_data, bus.out_row, bus.out_col} !== 20'd0) begin
            errors++;
            $display("FAIL midrst_data: got data=%0d row=%0d col=%0d want 0", bus.out_data, bus.out_row, bus.out_col);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        random_matrix();
        drive_matrix();
        build_expected(4);
        capture(4, 1'b0, w, ok);
        collect(0);
        checks++;
        if (timed_out || n_beats != NEL || b_row[0] != 0 || b_col[0] != 0) begin
            errors++;
            $display("FAIL midrst_restart: beats=%0d first r=%0d c=%0d want 16 0 0", n_beats, b_row[0], b_col[0]);
        end
        for (int k = 0; k < NEL && k < n_beats; k++) begin
            checks++;
            if ({b_data[k], b_row[k], b_col[k]} !== {e_data[k], e_row[k], e_col[k]}) begin
                errors++;
                $display("FAIL midrst_beat%0d: got d=%0d r=%0d c=%0d want d=%0d r=%0d c=%0d", k, b_data[k], b_row[k], b_col[k], e_data[k], e_row[k], e_col[k]);
            end
        end
    endtask

    task automatic test_overlap();
        int w; bit ok;
        longint ea [NEL];
        random_matrix();
        drive_matrix();
        build_expected(5);
        for (int k = 0; k < NEL; k++) ea[k] = e_data[k];
        capture(5, 1'b1, w, ok);
        // New matrix and shift presented while the first one drains.
        random_matrix();
        drive_matrix();
        bus.shift_amt = 5'd1;
        collect(2);
        checks++;
        if (timed_out || n_beats != NEL) begin
            errors++;
            $display("FAIL ovl_first_count: timeout=%b beats=%0d want 0 16", timed_out, n_beats);
        end
        for (int k = 0; k < NEL && k < n_beats; k++) begin
            checks++;
            if (b_data[k] != ea[k]) begin
                errors++;
                $display("FAIL ovl_first_beat%0d: got %0d want %0d", k, b_data[k], ea[k]);
            end
        end
        build_expected(1);
        capture(1, 1'b0, w, ok);
        checks++;
        if (!ok || w != 0) begin
            errors++;
            $display("FAIL ovl_capture_gap: waited %0d cycles ok=%b want 0 1", w, ok);
        end
        collect(0);
        for (int k = 0; k < NEL && k < n_beats; k++) begin
            checks++;
            if ({b_data[k], b_row[k], b_col[k], b_last[k]} !== {e_data[k], e_row[k], e_col[k], e_last[k]}) begin
                errors++;
                $display("FAIL ovl_second_beat%0d: got d=%0d r=%0d c=%0d want d=%0d r=%0d c=%0d", k, b_data[k], b_row[k], b_col[k], e_data[k], e_row[k], e_col[k]);
            end
        end
    endtask

    task automatic test_random();
        int w; bit ok; int sh;
        for (int t = 0; t < 4; t++) begin
            random_matrix();
            drive_matrix();
            sh = $urandom_range(0, 31);
            build_expected(sh);
            capture(sh, 1'b0, w, ok);
            collect(2);
            checks++;
            if (timed_out || n_beats != NEL || bus.sat_flag !== e_sat) begin
                errors++;
                $display("FAIL rand%0d_summary: beats=%0d sat=%b want 16 %b", t, n_beats, bus.sat_flag, e_sat);
            end
            for (int k = 0; k < NEL && k < n_beats; k++) begin
                checks++;
                if ({b_data[k], b_row[k], b_col[k], b_last[k]} !== {e_data[k], e_row[k], e_col[k], e_last[k]}) begin
                    errors++;
                    $display("FAIL rand%0d_beat%0d: got d=%0d r=%0d c=%0d want d=%0d r=%0d c=%0d (shift %0d)", t, k, b_data[k], b_row[k], b_col[k], e_data[k], e_row[k], e_col[k], sh);
                end
            end
        end
    endtask

    initial begin
        pat6[0] = 1'b1; pat6[1] = 1'b0; pat6[2] = 1'b0;
        pat6[3] = 1'b1; pat6[4] = 1'b0; pat6[5] = 1'b1;
        test_reset();
        test_order();
        test_rounding();
        test_saturation();
        test_backpressure();
        test_reset_mid();
        test_overlap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global bound in case the stream never completes.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_sa_output_drain
`default_nettype wire
